// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate/colour types and the vertical scan-state encoding.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_CLK_DIV   = 2;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [7:0] R;
        logic [7:0] G;
        logic [7:0] B;
    } rgb_t;

    typedef enum logic [1:0] {
        ACTIVE,
        VFP,
        VSYNC,
        VBP
    } scan_state_t;

endpackage

// File: rtl/vga_scan_gen_if.sv
// Raster bus: scan coordinates out to the colour mapper, its colour back in, and the DAC pins.
interface vga_scan_gen_if;
    import vga_pkg::*;

    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    coord_t     DrawX;
    coord_t     DrawY;
    logic       pixel_clk;
    logic       pix_en;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       sync_n;
    logic       frame_start;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        input  Red, Green, Blue,
        output DrawX, DrawY, pixel_clk, pix_en, hs, vs, blank_n, sync_n,
               frame_start, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        output Red, Green, Blue,
        input  DrawX, DrawY, pixel_clk, pix_en, hs, vs, blank_n, sync_n,
               frame_start, VGA_R, VGA_G, VGA_B
    );

endinterface

// File: rtl/vga_pix_div.sv
// Divides the system clock into a one-clock pix_en pulse and a ~50% duty pixel_clk.
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic pix_en,
    output logic pixel_clk
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] DIV_HALF = 4'(CLK_DIV / 2);

    logic [3:0] div;
    logic [3:0] div_nxt;

    always_comb begin
        div_nxt = (div == DIV_LAST) ? 4'd0 : div + 4'd1;
    end

    // pixel_clk follows the new divider value so it is high for div >= CLK_DIV/2
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div       <= 4'd0;
            pix_en    <= 1'b0;
            pixel_clk <= 1'b0;
        end else begin
            div       <= div_nxt;
            pix_en    <= (div == DIV_LAST);
            pixel_clk <= (div_nxt >= DIV_HALF);
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: scan counters, registered HS/VS/blank and blank-gated DAC colour.
// Optional macro VGA_PIPE_ALIGN_EN adds a one-pixel stage on syncs/blank and registers mapper colour.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic           Clk,
    input  logic           Reset_n,
    vga_scan_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_END = coord_t'(H_VISIBLE);
    localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t V_ACT_END = coord_t'(V_VISIBLE);
    localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_scan_gen: H_TOTAL=%0d / V_TOTAL=%0d do not fit 10-bit counters", H_TOTAL, V_TOTAL);
    end
    if (CLK_DIV < 2 || CLK_DIV > 8) begin : g_div_check
        $error("vga_scan_gen: CLK_DIV=%0d outside 2..8", CLK_DIV);
    end

    logic        pix_en;
    logic        pixel_clk;
    logic        pix_d;
    coord_t      hc;
    coord_t      vc;
    scan_state_t v_state;
    coord_t      draw_x;
    coord_t      draw_y;
    logic        hs_r;
    logic        vs_r;
    logic        blank_r;
    logic        frame_start;
    rgb_t        mapper_rgb;
    rgb_t        vga_rgb;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk       (Clk),
        .reset_n   (Reset_n),
        .pix_en    (pix_en),
        .pixel_clk (pixel_clk)
    );

    assign mapper_rgb = {vga.Red, vga.Green, vga.Blue};

    // pix_d marks the clock right after hc/vc moved, when the new position is presented
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hc    <= '0;
            vc    <= '0;
            pix_d <= 1'b0;
        end else begin
            pix_d <= pix_en;
            if (pix_en) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? coord_t'(0) : vc + coord_t'(1);
                end else begin
                    hc <= hc + coord_t'(1);
                end
            end
        end
    end

    always_comb begin
        if (vc < V_ACT_END) begin
            v_state = ACTIVE;
        end else if (vc < VS_START) begin
            v_state = VFP;
        end else if (vc < VS_END) begin
            v_state = VSYNC;
        end else begin
            v_state = VBP;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            draw_x      <= '0;
            draw_y      <= '0;
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            blank_r     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            draw_x      <= hc;
            draw_y      <= vc;
            hs_r        <= !((hc >= HS_START) && (hc < HS_END));
            vs_r        <= (v_state != VSYNC);
            blank_r     <= (hc < H_ACT_END) && (v_state == ACTIVE);
            frame_start <= pix_d && (hc == '0) && (vc == '0);
        end
    end

`ifdef VGA_PIPE_ALIGN_EN
    logic hs_d;
    logic vs_d;
    logic blank_d;
    rgb_t rgb_cap;

    // Colour is sampled mid-pixel; syncs and colour then shift together one pixel behind DrawX
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            blank_d <= 1'b0;
            rgb_cap <= '0;
            vga_rgb <= '0;
        end else begin
            if (pix_en) begin
                rgb_cap <= mapper_rgb;
            end
            if (pix_d) begin
                hs_d    <= hs_r;
                vs_d    <= vs_r;
                blank_d <= blank_r;
                vga_rgb <= blank_r ? rgb_cap : '0;
            end
        end
    end

    assign vga.hs      = hs_d;
    assign vga.vs      = vs_d;
    assign vga.blank_n = blank_d;
`else
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vga_rgb <= '0;
        end else begin
            vga_rgb <= blank_r ? mapper_rgb : '0;
        end
    end

    assign vga.hs      = hs_r;
    assign vga.vs      = vs_r;
    assign vga.blank_n = blank_r;
`endif

    assign vga.DrawX       = draw_x;
    assign vga.DrawY       = draw_y;
    assign vga.pix_en      = pix_en;
    assign vga.pixel_clk   = pixel_clk;
    assign vga.sync_n      = 1'b0;
    assign vga.frame_start = frame_start;
    assign vga.VGA_R       = vga_rgb.R;
    assign vga.VGA_G       = vga_rgb.G;
    assign vga.VGA_B       = vga_rgb.B;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: default horizontal timing, shortened vertical timing (11 lines).
`timescale 1ns/1ps
module tb_vga_scan_gen;
    import vga_pkg::*;

    localparam int V_VIS_TB   = 6;
    localparam int V_FP_TB    = 2;
    localparam int V_SYNC_TB  = 2;
    localparam int V_BP_TB    = 1;
    localparam int FRAME_CLKS = 2 * 800 * 11;
    localparam int WAIT_LIMIT = 40000;
`ifdef VGA_PIPE_ALIGN_EN
    localparam int SYNC_LAG = 2;
`else
    localparam int SYNC_LAG = 0;
`endif

    typedef struct {
        int         x;
        int         y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    vec_t vecs[17];

    vga_scan_gen_if vif ();

    vga_scan_gen #(
        .H_VISIBLE (640),
        .H_FP      (16),
        .H_SYNC    (96),
        .H_BP      (48),
        .V_VISIBLE (V_VIS_TB),
        .V_FP      (V_FP_TB),
        .V_SYNC    (V_SYNC_TB),
        .V_BP      (V_BP_TB),
        .CLK_DIV   (2)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .vga     (vif)
    );

    always #10 Clk = ~Clk;

    // Mapper stand-in: constant red/green, blue tracks DrawX so pixel alignment is visible
    assign vif.Red   = 8'hFF;
    assign vif.Green = 8'h55;
    assign vif.Blue  = vif.DrawX[7:0];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst_n, input int cycles);
        Reset_n = rst_n;
        repeat (cycles) tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: timed out after %0d clocks", name, WAIT_LIMIT);
    endtask

    task automatic waitFor(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            tick();
            if (int'(vif.DrawX) == x && int'(vif.DrawY) == y) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit   ok;
        bit   found;
        bit   rise_seen;
        logic prev;
        int   elapsed;

        vecs[0]  = '{2,   0,  1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h55, 8'h02};
        vecs[1]  = '{639, 0,  1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h55, 8'h7F};
        vecs[2]  = '{655, 0,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{751, 0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{0,   1,  1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h55, 8'h00};
        vecs[5]  = '{640, 1,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{656, 1,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{752, 1,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{799, 1,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{100, 5,  1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h55, 8'h64};
        vecs[10] = '{100, 6,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{0,   7,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[12] = '{0,   8,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[13] = '{797, 9,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[14] = '{0,   10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[15] = '{797, 10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[16] = '{0,   0,  1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h55, 8'h00};

        $display("[TB] reset values");
        applyStimulus(1'b0, 3);
        checkOutput("rst_DrawX",       32'(vif.DrawX),       32'd0);
        checkOutput("rst_DrawY",       32'(vif.DrawY),       32'd0);
        checkOutput("rst_pixel_clk",   32'(vif.pixel_clk),   32'd0);
        checkOutput("rst_pix_en",      32'(vif.pix_en),      32'd0);
        checkOutput("rst_hs",          32'(vif.hs),          32'd1);
        checkOutput("rst_vs",          32'(vif.vs),          32'd1);
        checkOutput("rst_blank_n",     32'(vif.blank_n),     32'd0);
        checkOutput("rst_sync_n",      32'(vif.sync_n),      32'd0);
        checkOutput("rst_frame_start", 32'(vif.frame_start), 32'd0);
        checkOutput("rst_VGA_R",       32'(vif.VGA_R),       32'd0);
        checkOutput("rst_VGA_G",       32'(vif.VGA_G),       32'd0);
        checkOutput("rst_VGA_B",       32'(vif.VGA_B),       32'd0);

        $display("[TB] reset release");
        applyStimulus(1'b1, 1);
        checkOutput("rel1_pix_en",    32'(vif.pix_en),    32'd0);
        checkOutput("rel1_pixel_clk", 32'(vif.pixel_clk), 32'd1);
        tick();
        checkOutput("rel2_pix_en",    32'(vif.pix_en),    32'd1);
        checkOutput("rel2_pixel_clk", 32'(vif.pixel_clk), 32'd0);
        tick();
        checkOutput("rel3_pix_en", 32'(vif.pix_en), 32'd0);
        checkOutput("rel3_DrawX",  32'(vif.DrawX),  32'd0);
        tick();
        checkOutput("rel4_DrawX",  32'(vif.DrawX),  32'd1);
        checkOutput("rel4_pix_en", 32'(vif.pix_en), 32'd1);

        $display("[TB] scan table");
        for (int i = 0; i < 17; i++) begin
            waitFor(vecs[i].x, vecs[i].y, ok);
            if (!ok) begin
                timeoutFail($sformatf("wait_vec%0d", i));
                continue;
            end
            checkOutput($sformatf("v%0d_frame_start", i), 32'(vif.frame_start), 32'(vecs[i].fs));
            checkOutput($sformatf("v%0d_sync_n", i),      32'(vif.sync_n),      32'd0);
            repeat (SYNC_LAG) tick();
            checkOutput($sformatf("v%0d_hs", i),      32'(vif.hs),      32'(vecs[i].hs));
            checkOutput($sformatf("v%0d_vs", i),      32'(vif.vs),      32'(vecs[i].vs));
            checkOutput($sformatf("v%0d_blank_n", i), 32'(vif.blank_n), 32'(vecs[i].bl));
            tick();
            checkOutput($sformatf("v%0d_VGA_R", i), 32'(vif.VGA_R), 32'(vecs[i].r));
            checkOutput($sformatf("v%0d_VGA_G", i), 32'(vif.VGA_G), 32'(vecs[i].g));
            checkOutput($sformatf("v%0d_VGA_B", i), 32'(vif.VGA_B), 32'(vecs[i].b));
        end

        $display("[TB] frame period");
        elapsed = 1 + SYNC_LAG;
        found   = 1'b0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            tick();
            elapsed++;
            if (vif.frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            timeoutFail("frame_start_next");
        end else begin
            checkOutput("frame_period", 32'(elapsed), 32'(FRAME_CLKS));
            checkOutput("frame_DrawY",  32'(vif.DrawY), 32'd0);
            tick();
            checkOutput("frame_start_width", 32'(vif.frame_start), 32'd0);
            checkOutput("frame_DrawX_hold",  32'(vif.DrawX),       32'd0);
        end

        $display("[TB] line timing");
        found = 1'b0;
        prev  = vif.hs;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            tick();
            if (prev === 1'b1 && vif.hs === 1'b0) begin
                found = 1'b1;
                break;
            end
            prev = vif.hs;
        end
        if (!found) begin
            timeoutFail("hs_fall");
        end else begin
            checkOutput("hs_fall_DrawX", 32'(vif.DrawX), 32'(656 + SYNC_LAG / 2));
            elapsed   = 0;
            found     = 1'b0;
            rise_seen = 1'b0;
            prev      = vif.hs;
            for (int i = 0; i < WAIT_LIMIT; i++) begin
                tick();
                elapsed++;
                if (!rise_seen && prev === 1'b0 && vif.hs === 1'b1) begin
                    rise_seen = 1'b1;
                    checkOutput("hs_rise_DrawX", 32'(vif.DrawX), 32'(752 + SYNC_LAG / 2));
                end
                if (prev === 1'b1 && vif.hs === 1'b0) begin
                    found = 1'b1;
                    break;
                end
                prev = vif.hs;
            end
            if (!found) begin
                timeoutFail("hs_second_fall");
            end else begin
                checkOutput("line_period", 32'(elapsed), 32'd1600);
            end
        end

        $display("[TB] mid-frame reset");
        waitFor(700, 8, ok);
        if (!ok) begin
            timeoutFail("wait_midframe");
        end else begin
            applyStimulus(1'b0, 1);
            checkOutput("mid_DrawX",   32'(vif.DrawX),   32'd0);
            checkOutput("mid_DrawY",   32'(vif.DrawY),   32'd0);
            checkOutput("mid_hs",      32'(vif.hs),      32'd1);
            checkOutput("mid_vs",      32'(vif.vs),      32'd1);
            checkOutput("mid_blank_n", 32'(vif.blank_n), 32'd0);
            checkOutput("mid_pix_en",  32'(vif.pix_en),  32'd0);
            applyStimulus(1'b1, 1);
            checkOutput("mid_rel1_pix_en", 32'(vif.pix_en), 32'd0);
            tick();
            checkOutput("mid_rel2_pix_en", 32'(vif.pix_en), 32'd1);
            tick();
            tick();
            checkOutput("mid_rel4_DrawX", 32'(vif.DrawX), 32'd1);
            checkOutput("mid_rel4_DrawY", 32'(vif.DrawY), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
